// File: rtl/line_fetch_sched.sv
// Per-frame line-fetch scheduler: turns vs/hs timing pulses into one address
// request per line and owns the front/back frame buffer swap.
module line_fetch_sched #(
    parameter int unsigned HEIGHT     = 1080,
    parameter int unsigned LINE_BYTES = 384
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic                      vs_i,
    input  logic                      hs_i,
    input  logic [31:0]               base0_i,
    input  logic [31:0]               base1_i,
    input  logic                      wr_done_i,
    output logic                      aval_o,
    output logic [31:0]               addr_o,
    output logic                      en_o,
    output logic                      buf_o,
    output logic [$clog2(HEIGHT)-1:0] line_o,
    output logic                      overrun_o
);

    localparam int unsigned LW = $clog2(HEIGHT);
    localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic            aval_q, aval_d;
    logic [31:0]     addr_q, addr_d;
    logic            en_q, en_d;
    logic            buf_q, buf_d;
    logic [LW-1:0]   line_q, line_d;
    logic            ovr_q, ovr_d;
    logic            pend_q, pend_d;
    logic            last_line;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        line_d    = line_q;
        ovr_d     = ovr_q;
        pend_d    = pend_q;
        last_line = (line_q == LAST_LINE);

        // vs restarts the frame from any state and swallows a coincident hs
        if (vs_i) begin
            buf_d   = buf_q ^ (pend_q | wr_done_i);
            pend_d  = 1'b0;
            line_d  = '0;
            addr_d  = buf_d ? base1_i : base0_i;
            state_d = ISSUE;
        end else begin
            if (wr_done_i) pend_d = 1'b1;
            case (state_q)
                ISSUE: begin
                    state_d = last_line ? DONE : WAIT;
                    if (hs_i) ovr_d = 1'b1;
                end
                WAIT: begin
                    if (hs_i) begin
                        if (last_line) begin
                            state_d = DONE;
                        end else begin
                            line_d  = line_q + 1'b1;
                            addr_d  = addr_q + 32'(LINE_BYTES);
                            state_d = ISSUE;
                        end
                    end
                end
                default: ;
            endcase
        end

        aval_d = (state_d == ISSUE);
        en_d   = en_i & (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            aval_q  <= 1'b0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            buf_q   <= 1'b0;
            line_q  <= '0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (srst_i) begin
            state_q <= IDLE;
            aval_q  <= 1'b0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            buf_q   <= 1'b0;
            line_q  <= '0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aval_q  <= aval_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    assign aval_o    = aval_q;
    assign addr_o    = addr_q;
    assign en_o      = en_q;
    assign buf_o     = buf_q;
    assign line_o    = line_q;
    assign overrun_o = ovr_q;

endmodule
